itof_arb: RTL and testbench

Arbiter and sequencer that shares one fixed-latency integer-to-float conversion unit between two requesters. Accepts 32-bit signed integers on two valid/ready request ports, issues at most one operand per cycle to the unstallable conversion pipeline, and tags every issue so each result returns to its requester. Results go into per-requester result FIFOs. Issue is credit-gated, so a result never arrives without buffer space.

---
 rtl/itof_arb.sv | 165 ++++++++++++++++
 tb/tb_itof_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_arb.sv
// Two-port arbiter sharing one fixed-latency int-to-float unit.
// Ports: req0/1 valid/ready/x in, cv_x/cv_y unit link,
//   rsp0/1 valid/ready/y out, busy. ITOF_ARB_RR_EN: round-robin.
module itof_arb #(
  parameter int LAT   = 1,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  output logic        req1_ready,
  output logic [31:0] cv_x,
  input  logic [31:0] cv_y,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_y,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_y,
  input  logic        rsp1_ready,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]     valid;
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     push;
  logic [1:0]     pop;
  logic [1:0]     rsp_r;
  logic [1:0]     nz;
  logic [LAT-1:0] tv;
  logic [LAT-1:0] tid;

  assign valid = {req1_valid, req0_valid};
  assign rsp_r = {rsp1_ready, rsp0_ready};

`ifdef ITOF_ARB_RR_EN
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (rstn) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b1;
    end else if (|grant) begin
      ptr <= grant[1];
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (rstn) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end
`endif

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    cv_x = 32'h0;
    unique case (1'b1)
      grant[0]: cv_x = req0_x;
      grant[1]: cv_x = req1_x;
      default:  cv_x = 32'h0;
    endcase
  end

  // Tag pipe tracks which requester owns each cv_y slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tv  <= '0;
      tid <= '0;
    end else begin
      tv[0]  <= |grant;
      tid[0] <= grant[1];
      for (int i = 1; i < LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
    end
  end

  assign push[0] = tv[LAT-1] & ~tid[LAT-1];
  assign push[1] = tv[LAT-1] & tid[LAT-1];

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar r = 0; r < 2; r++) begin : g_q
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] fc;
    logic [CW-1:0] cnt;
    logic [31:0]   head;

    assign head    = mem[rp];
    assign elig[r] = valid[r] & (cnt < CW'(DEPTH));
    assign pop[r]  = (fc != '0) & rsp_r[r];
    assign nz[r]   = cnt != '0;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp  <= '0;
        rp  <= '0;
        fc  <= '0;
        cnt <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push[r]) begin
          mem[wp] <= cv_y;
          wp      <= inc(wp);
        end
        if (pop[r]) begin
          rp <= inc(rp);
        end
        fc  <= fc + CW'(push[r]) - CW'(pop[r]);
        // Credits: in flight plus buffered.
        cnt <= cnt + CW'(grant[r]) - CW'(pop[r]);
      end
    end

`ifndef SYNTHESIS
    a_no_ovf: assert property (
      @(posedge clk) disable iff (!rstn)
      push[r] |-> (fc != CW'(DEPTH))
    );
`endif
  end

  assign rsp0_valid = g_q[0].fc != '0;
  assign rsp1_valid = g_q[1].fc != '0;
  assign rsp0_y     = g_q[0].head;
  assign rsp1_y     = g_q[1].head;
  assign busy       = |nz;

endmodule

// File: tb/tb_itof_arb.sv
// Bench for itof_arb with a truncating LAT-cycle
// int-to-float unit model and per-requester scoreboards.
module tb_itof_arb;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_x, req1_x;
  logic        req0_ready, req1_ready;
  logic [31:0] cv_x, cv_y;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_y, rsp1_y;
  logic        rsp0_ready, rsp1_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] cvp [LAT];

  always #5 clk = ~clk;

  itof_arb #(.LAT(LAT), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_x(req0_x),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_x(req1_x),
    .req1_ready(req1_ready),
    .cv_x(cv_x), .cv_y(cv_y),
    .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y),
    .rsp1_ready(rsp1_ready),
    .busy(busy)
  );

  // Round-toward-zero conversion.
  function automatic logic [31:0] i2f(
    input logic [31:0] x
  );
    logic [31:0] m;
    logic [31:0] mn;
    int p;
    if (x == 32'h0) return 32'h0;
    m = x[31] ? (~x + 32'h1) : x;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (m[i]) p = i;
    if (p <= 23) mn = m << (23 - p);
    else mn = m >> (p - 23);
    return {x[31], 8'(127 + p), mn[22:0]};
  endfunction

  always @(posedge clk) begin
    cvp[0] <= i2f(cv_x);
    for (int i = 1; i < LAT; i++)
      cvp[i] <= cvp[i-1];
  end
  assign cv_y = cvp[LAT-1];

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] ex;
    if (!rstn) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req0_valid && req0_ready)
        q0.push_back(i2f(req0_x));
      if (req1_valid && req1_ready)
        q1.push_back(i2f(req1_x));
      chk("onehot", {31'b0, req0_ready & req1_ready}, 0);
      ex = req0_ready ? req0_x :
           req1_ready ? req1_x : 32'h0;
      chk("cv_x", cv_x, ex);
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0)
          chk("rsp0_extra", {31'b0, rsp0_valid}, 0);
        else
          chk("rsp0_y", rsp0_y, q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0)
          chk("rsp1_extra", {31'b0, rsp1_valid}, 0);
        else
          chk("rsp1_y", rsp1_y, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(
    input int n,
    input logic [31:0] x,
    input logic [31:0] exp
  );
    if (n == 0) begin
      req0_valid = 1'b1; req0_x = x;
    end else begin
      req1_valid = 1'b1; req1_x = x;
    end
    @(negedge clk);
    chk("one_rdy", {31'b0, n == 0 ? req0_ready : req1_ready}, 1);
    chk("one_cvx", cv_x, x);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("one_early", {31'b0, n == 0 ? rsp0_valid : rsp1_valid}, 0);
    @(negedge clk);
    chk("one_vld", {31'b0, n == 0 ? rsp0_valid : rsp1_valid}, 1);
    chk("one_y", n == 0 ? rsp0_y : rsp1_y, exp);
    tick();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy && q0.size() == 0 && q1.size() == 0)
        done = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("drain_busy", {31'b0, busy}, 0);
    chk("drain_q", q0.size() + q1.size(), 0);
    tick();
  endtask

  initial begin
    int n0, n1, cyc;
    logic [1:0] ex;
    rstn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = 32'h0; req1_x = 32'h0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 32'h5; req1_x = 32'h7;
    @(negedge clk);
    chk("rst_rdy", {30'b0, req1_ready, req0_ready}, 0);
    chk("rst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cvx", cv_x, 0);
    chk("rst_y0", rsp0_y, 0);
    chk("rst_y1", rsp1_y, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rstn = 1'b1;
    tick();

    do_one(0, 32'h00000005, 32'h40A00000);
    do_one(1, 32'h00000000, 32'h00000000);
    do_one(1, 32'hFFFFFFFF, 32'hBF800000);
    do_one(1, 32'h00000001, 32'h3F800000);
    do_one(1, 32'h80000001, 32'hCEFFFFFF);

    // Tie run straight out of reset.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req0_x = $urandom; req1_x = $urandom;
`ifdef ITOF_ARB_RR_EN
      ex = (c % 2 == 1) ? 2'b10 : 2'b01;
`else
      ex = (c % 3 == 2) ? 2'b10 : 2'b01;
`endif
      @(negedge clk);
      chk("tie", {30'b0, req1_ready, req0_ready}, {30'b0, ex});
      tick();
    end
    drain();

    // Back-pressure on rsp0.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req0_x = $urandom;
      @(negedge clk);
      chk("bp0", {31'b0, req0_ready}, (c < 2) ? 1 : 0);
      tick();
    end
    req1_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req0_x = $urandom; req1_x = $urandom;
      @(negedge clk);
      chk("bp0_hold", {31'b0, req0_ready}, 0);
      chk("bp1", {31'b0, req1_ready}, (c % 3 != 2) ? 1 : 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_rsp0", {31'b0, rsp0_valid}, 1);
    tick();
    rsp0_ready = 1'b1;
    drain();

    // Reset with two ops in flight.
    req0_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req0_x = 32'h100 + c;
      @(negedge clk);
      chk("mf_acc", {31'b0, req0_ready}, 1);
      if (c == 0) tick();
    end
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mf_rdy", {31'b0, req0_ready}, 0);
    chk("mf_busy", {31'b0, busy}, 0);
    chk("mf_rsp", {31'b0, rsp0_valid}, 0);
    chk("mf_cvx", cv_x, 0);
    #1;
    rstn = 1'b1;
    req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mf_none", {30'b0, rsp1_valid, rsp0_valid}, 0);
      chk("mf_idle", {31'b0, busy}, 0);
      tick();
    end
    do_one(0, 32'h00000003, 32'h40400000);

    // Random traffic.
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 < 200 || n1 < 200) && cyc < 20000) begin
      req0_valid = (n0 < 200) && ($urandom % 2 == 0);
      req1_valid = (n1 < 200) && ($urandom % 2 == 0);
      req0_x = $urandom; req1_x = $urandom;
      rsp0_ready = ($urandom % 4 != 0);
      rsp1_ready = ($urandom % 3 != 0);
      @(negedge clk);
      if (req0_valid && req0_ready) n0++;
      if (req1_valid && req1_ready) n1++;
      cyc++;
      tick();
    end
    chk("rnd_n0", n0, 200);
    chk("rnd_n1", n1, 200);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
